prefix32sub_pipe: RTL and testbench

Pipelined 32-bit parallel-prefix (Kogge-Stone) subtractor computing a − b − bin. It is the subtract-direction counterpart of the team's pipelined prefix adder and feeds the ALU's SUB/CMP path. It registers results over three stages with a valid tag and a global stall, and produces borrow, signed-overflow and zero flags.

---
 rtl/prefix32sub_pipe.sv | 96 +++++++++
 tb/tb_prefix32sub_pipe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/prefix32sub_pipe.sv
// prefix32sub_pipe: three-stage Kogge-Stone subtractor computing a - b - bin
// with borrow, signed-overflow and zero flags, a valid tag and a global stall.
module prefix32sub_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    input  logic        in_valid,
    input  logic        stall,
    output logic [31:0] d,
    output logic        bout,
    output logic        ovf,
    output logic        zero,
    output logic        out_valid
);
    // One Kogge-Stone level: bits below span keep their group (G, P) unchanged.
    function automatic logic [63:0] prefix_level(input logic [31:0] g, input logic [31:0] p, input int s);
        logic [31:0] gn;
        logic [31:0] pn;
        gn = g | (p & (g << s));
        pn = p & ((p << s) | ((32'd1 << s) - 32'd1));
        return {gn, pn};
    endfunction

    logic [31:0] g1, p1;
    logic        c1, m1, v1;
    logic [31:0] g2, p2, q2;
    logic        c2, m2, v2;
    logic [31:0] g_l1, p_l1, g_l2, p_l2, g_l3, p_l3;
    logic [31:0] g_l4, p_l4, g_l5, p_l5;
    logic [31:0] carries, d_next;
    logic        carry_out;

    // m1/m2 carry a[31] forward so the overflow test can see the minuend sign.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g1 <= '0;
            p1 <= '0;
            c1 <= 1'b0;
            m1 <= 1'b0;
            v1 <= 1'b0;
        end else if (!stall) begin
            g1 <= a & ~b;
            p1 <= a ^ ~b;
            c1 <= ~bin;
            m1 <= a[31];
            v1 <= in_valid;
        end
    end

    assign {g_l1, p_l1} = prefix_level(g1, p1, 1);
    assign {g_l2, p_l2} = prefix_level(g_l1, p_l1, 2);
    assign {g_l3, p_l3} = prefix_level(g_l2, p_l2, 4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g2 <= '0;
            p2 <= '0;
            q2 <= '0;
            c2 <= 1'b0;
            m2 <= 1'b0;
            v2 <= 1'b0;
        end else if (!stall) begin
            g2 <= g_l3;
            p2 <= p_l3;
            q2 <= p1;
            c2 <= c1;
            m2 <= m1;
            v2 <= v1;
        end
    end

    assign {g_l4, p_l4} = prefix_level(g2, p2, 8);
    assign {g_l5, p_l5} = prefix_level(g_l4, p_l4, 16);
    assign carries   = {g_l5[30:0] | (p_l5[30:0] & {31{c2}}), c2};
    assign carry_out = g_l5[31] | (p_l5[31] & c2);
    assign d_next    = q2 ^ carries;

    // q2[31] is a XNOR b at the sign bit, so 0 means the operand signs differ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            d         <= d_next;
            bout      <= ~carry_out;
            ovf       <= ~q2[31] & (d_next[31] ^ m2);
            zero      <= d_next == 32'd0;
            out_valid <= v2;
        end
    end
endmodule

// File: tb/tb_prefix32sub_pipe.sv
// tb_prefix32sub_pipe: directed vectors with hand-computed results, checked
// by a scoreboard monitor that pops whenever a fresh result is presented.
module tb_prefix32sub_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        bin = 1'b0, in_valid = 1'b0, stall = 1'b0;
    logic [31:0] d;
    logic        bout, ovf, zero, out_valid;

    typedef struct {
        logic [31:0] d;
        logic        b;
        logic        o;
        int          k;
    } exp_t;

    exp_t q[$];
    exp_t last;
    logic have_last = 1'b0;
    logic adv = 1'b0;
    int   adv_cnt = 0;
    int   passed = 0, total = 0;

    prefix32sub_pipe dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
        .stall(stall), .d(d), .bout(bout), .ovf(ovf), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        else passed++;
    endtask

    // adv_cnt counts edges on which the pipeline actually advanced.
    always @(posedge clk) begin
        adv <= !stall && reset;
        if (!stall && reset) adv_cnt <= adv_cnt + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && adv) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    last = q.pop_front();
                    have_last = 1'b1;
                    check("d", d, last.d);
                    check("bout", {31'd0, bout}, {31'd0, last.b});
                    check("ovf", {31'd0, ovf}, {31'd0, last.o});
                    check("zero", {31'd0, zero}, {31'd0, last.d == 32'd0});
                    check("latency", adv_cnt, last.k + 2);
                end
            end else if (!adv && out_valid && have_last) begin
                check("frozen_d", d, last.d);
                check("frozen_bout", {31'd0, bout}, {31'd0, last.b});
            end
        end
    end

    task automatic op(input logic [31:0] ta, input logic [31:0] tb2, input logic tbi,
                      input logic tv, input logic ts,
                      input logic [31:0] ed, input logic eb, input logic eo);
        @(posedge clk);
        #1;
        a = ta; b = tb2; bin = tbi; in_valid = tv; stall = ts;
        if (tv && !ts) q.push_back('{ed, eb, eo, adv_cnt + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_cleared(input string nm);
        check({nm, "_d"}, d, 32'd0);
        check({nm, "_flags"}, {28'd0, bout, ovf, zero, out_valid}, 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            a = $urandom; b = $urandom; bin = 1'($urandom); in_valid = 1'($urandom); stall = 1'($urandom);
            @(negedge clk);
            check_cleared("reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0;

        op(32'h44444444, 32'h33333333, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0);
        idle(4);
        op(32'h11111111, 32'h33333333, 1'b1, 1'b1, 1'b0, 32'hDDDDDDDD, 1'b1, 1'b0);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0);
        op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
        op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b1);
        op(32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        op(32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0);
        idle(4);

        op(32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b0);
        op(32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        op(32'hDEADBEEF, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        op(32'hCAFEF00D, 32'h00000002, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        op(32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0);
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        idle(5);

        op(32'h00000010, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h0000000F, 1'b0, 1'b0);
        op(32'h00000020, 32'h00000002, 1'b0, 1'b1, 1'b0, 32'h0000001E, 1'b0, 1'b0);
        op(32'h00000030, 32'h00000003, 1'b0, 1'b1, 1'b0, 32'h0000002D, 1'b0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_cleared("midreset");
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(5);
        op(32'h00001000, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h00000FFE, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check("drained", q.size(), 32'd0);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
